// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq. blank_mask exists only when
// BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank_mask;

    modport master (output start, bin_in, input busy, done, bcd_out, blank_mask);
    modport slave  (input start, bin_in, output busy, done, bcd_out, blank_mask);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blank_mask output.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    bin2bcd_seq_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] scratch_q, scratch_d, scratch_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             done_q, done_d;

    // Add-3 correction so each digit carries into the next one after the shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = {scratch_adj[BCD_W-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zero_above;

    // Walk from the top digit down; a digit blanks only while everything above it is zero.
    always_comb begin
        blank_d    = blank_q;
        zero_above = 1'b1;
        if (state_q == ST_DONE) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_above = zero_above && (scratch_q[4*i +: 4] == 4'd0);
                blank_d[i] = zero_above;
            end
            blank_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        else
            blank_q <= blank_d;
    end

    assign bus.blank_mask = blank_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomised checks of bin2bcd_seq at 8/3 and 16/5 configurations;
// blank_mask checks are compiled in when BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8 ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if16 ();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    int n_vec = 0;
    int n_err = 0;
    int done8_cnt = 0;
    int done16_cnt = 0;

    always @(negedge clk) begin
        if (if8.done  === 1'b1) done8_cnt++;
        if (if16.done === 1'b1) done16_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] to_bcd(input int unsigned v);
        logic [63:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one start for a single edge; bin_in is scrambled afterwards.
    task automatic pulse(input bit wide, input logic [15:0] v);
        if (wide) begin
            if16.start = 1'b1; if16.bin_in = v;
        end else begin
            if8.start = 1'b1; if8.bin_in = v[7:0];
        end
        tick();
        if (wide) begin
            if16.start = 1'b0; if16.bin_in = ~v;
        end else begin
            if8.start = 1'b0; if8.bin_in = ~v[7:0];
        end
    endtask

    task automatic wait_done(input bit wide, output int lat, output int busy_n);
        lat    = 0;
        busy_n = wide ? int'(if16.busy) : int'(if8.busy);
        while (!(wide ? if16.done : if8.done) && lat < 40) begin
            tick();
            lat++;
            busy_n += wide ? int'(if16.busy) : int'(if8.busy);
        end
        check(wide ? "done16 seen" : "done8 seen", wide ? if16.done : if8.done, 1'b1);
    endtask

    initial begin
        int lat;
        int busy_n;
        int d0;
        logic [15:0] v;

        rst = 1'b0;
        if8.start = 1'b0;  if8.bin_in = '0;
        if16.start = 1'b0; if16.bin_in = '0;
        #2 rst = 1'b1;
        #1;
        check("reset busy8", if8.busy, 1'b0);
        check("reset done8", if8.done, 1'b0);
        check("reset bcd8", if8.bcd_out, 12'h000);
        check("reset busy16", if16.busy, 1'b0);
        check("reset bcd16", if16.bcd_out, 20'h00000);
`ifdef BIN2BCD_BLANK_EN
        check("reset blank8", if8.blank_mask, 3'b110);
        check("reset blank16", if16.blank_mask, 5'b11110);
`endif
        repeat (2) tick();
        rst = 1'b0;

        // Max 8-bit operand: latency, busy length and single-cycle done.
        pulse(1'b0, 16'd255);
        check("start busy8", if8.busy, 1'b1);
        wait_done(1'b0, lat, busy_n);
        check("lat 255", 64'(lat), 64'd9);
        check("busy cycles 255", 64'(busy_n), 64'd9);
        check("bcd 255", if8.bcd_out, 12'h255);
`ifdef BIN2BCD_BLANK_EN
        check("blank 255", if8.blank_mask, 3'b000);
`endif
        tick();
        check("done pulse width", if8.done, 1'b0);
        check("bcd hold", if8.bcd_out, 12'h255);

        pulse(1'b0, 16'd0);
        wait_done(1'b0, lat, busy_n);
        check("bcd 0", if8.bcd_out, 12'h000);
`ifdef BIN2BCD_BLANK_EN
        check("blank 0", if8.blank_mask, 3'b110);
`endif
        tick();
        pulse(1'b0, 16'd99);
        wait_done(1'b0, lat, busy_n);
        check("bcd 99", if8.bcd_out, 12'h099);
`ifdef BIN2BCD_BLANK_EN
        check("blank 99", if8.blank_mask, 3'b100);
`endif
        tick();

        // A start raised while busy must be ignored.
        d0 = done8_cnt;
        pulse(1'b0, 16'd128);
        check("bcd held during conv", if8.bcd_out, 12'h099);
        repeat (2) tick();
        if8.start = 1'b1; if8.bin_in = 8'd7;
        tick();
        if8.start = 1'b0;
        wait_done(1'b0, lat, busy_n);
        check("lat after ignored start", 64'(lat), 64'd6);
        check("bcd 128", if8.bcd_out, 12'h128);
        repeat (12) tick();
        check("single done 128", 64'(done8_cnt - d0), 64'd1);
        check("idle after ignored start", if8.busy, 1'b0);

        // Reset mid-conversion aborts with no done pulse.
        d0 = done8_cnt;
        pulse(1'b0, 16'd200);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("abort busy", if8.busy, 1'b0);
        check("abort done", if8.done, 1'b0);
        check("abort bcd", if8.bcd_out, 12'h000);
`ifdef BIN2BCD_BLANK_EN
        check("abort blank", if8.blank_mask, 3'b110);
`endif
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("abort no done", 64'(done8_cnt - d0), 64'd0);
        check("abort bcd hold", if8.bcd_out, 12'h000);
        pulse(1'b0, 16'd42);
        check("first start after reset", if8.busy, 1'b1);
        wait_done(1'b0, lat, busy_n);
        check("bcd 42", if8.bcd_out, 12'h042);
`ifdef BIN2BCD_BLANK_EN
        check("blank 42", if8.blank_mask, 3'b100);
`endif
        tick();

        // 16-bit configuration.
        pulse(1'b1, 16'd65535);
        wait_done(1'b1, lat, busy_n);
        check("lat 65535", 64'(lat), 64'd17);
        check("busy cycles 65535", 64'(busy_n), 64'd17);
        check("bcd 65535", if16.bcd_out, 20'h65535);
        tick();
        pulse(1'b1, 16'd7);
        wait_done(1'b1, lat, busy_n);
        check("bcd 7", if16.bcd_out, 20'h00007);
`ifdef BIN2BCD_BLANK_EN
        check("blank 7", if16.blank_mask, 5'b11110);
`endif
        tick();

        // Back-to-back starts at minimum spacing, 8-bit.
        d0 = done8_cnt;
        for (int k = 0; k < 1000; k++) begin
            v = 16'($urandom_range(0, 255));
            pulse(1'b0, v);
            repeat (8) tick();
            check("rand8 early done", if8.done, 1'b0);
            tick();
            check("rand8 done", if8.done, 1'b1);
            check("rand8 bcd", if8.bcd_out, to_bcd(32'(v)));
        end
        repeat (2) tick();
        check("rand8 done count", 64'(done8_cnt - d0), 64'd1000);

        // Back-to-back starts at minimum spacing, 16-bit.
        d0 = done16_cnt;
        for (int k = 0; k < 300; k++) begin
            v = 16'($urandom_range(0, 65535));
            pulse(1'b1, v);
            repeat (17) tick();
            check("rand16 done", if16.done, 1'b1);
            check("rand16 bcd", if16.bcd_out, to_bcd(32'(v)));
        end
        repeat (2) tick();
        check("rand16 done count", 64'(done16_cnt - d0), 64'd300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
